// File: rtl/stim_gen.sv
// rtl/stim_gen.sv - parameterised burst stimulus generator (INC/DEC/LFSR/CONST data, stepped addresses)
module stim_gen #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ADDR_STEP  = 4,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = 32'h80200003
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [15:0]           len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_INC   = 2'd0;
    localparam logic [1:0] MODE_DEC   = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;
    localparam logic [1:0] MODE_CONST = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(ADDR_STEP);
    localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [15:0]             len_q, len_d;
    logic                    done_q, done_d;
    logic                    last_beat;
    logic [DATA_WIDTH-1:0]   data_next;

    // Current beat is the final one once the 16-bit beat index reaches len-1.
    assign last_beat = (state_q == RUN) && (cnt_q == (len_q - 16'd1));

    assign out_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign out_last  = last_beat;
    assign out_addr  = addr_q;
    assign out_data  = data_q;
    assign done      = done_q;

    // Data of the following beat for the latched pattern.
    always_comb begin
        data_next = data_q;
        case (mode_q)
            MODE_INC:   data_next = data_q + DATA_ONE;
            MODE_DEC:   data_next = data_q - DATA_ONE;
            MODE_LFSR:  data_next = data_q[0] ? ((data_q >> 1) ^ LFSR_TAPS) : (data_q >> 1);
            MODE_CONST: data_next = data_q;
            default:    data_next = data_q;
        endcase
    end

    // Next-state logic: latch burst on start, advance on handshake, abort wins over transfer.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != 16'd0) begin
                        state_d = RUN;
                        mode_d  = mode;
                        addr_d  = base_addr;
                        len_d   = len;
                        cnt_d   = 16'd0;
                        // An all-zero seed would lock the LFSR, so it is replaced by all-ones.
                        if (mode == MODE_LFSR && seed == '0) begin
                            data_d = '1;
                        end else begin
                            data_d = seed;
                        end
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + 16'd1;
                        addr_d = addr_q + STEP;
                        data_d = data_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            mode_q  <= 2'd0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= 16'd0;
            len_q   <= 16'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_stim_gen.sv
// tb/tb_stim_gen.sv - scoreboard testbench for stim_gen
module tb_stim_gen;

    localparam logic [31:0] TAPS = 32'h80200003;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] base_addr = '0;
    logic [31:0] seed = '0;
    logic [15:0] len = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    beat_t sb_q[$];

    stim_gen dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .base_addr (base_addr),
        .seed      (seed),
        .len       (len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [1:0] m, input logic [31:0] d);
        case (m)
            2'd0:    return d + 32'd1;
            2'd1:    return d - 32'd1;
            2'd2:    return d[0] ? ((d >> 1) ^ TAPS) : (d >> 1);
            default: return d;
        endcase
    endfunction

    // Drives one burst at posedge+1 timing; returns in the cycle after completion/abort/reset.
    task automatic burst(input logic [1:0] m, input logic [31:0] base, input logic [31:0] sd,
                         input logic [15:0] n, input bit toggle, input int abort_at,
                         input int reset_at, input bit abort_on_start, input bit noisy);
        logic [31:0] a;
        logic [31:0] d;
        int          k;
        int          cyc;
        bit          rdy;
        beat_t       b;
        a = base;
        d = (m == 2'd2 && sd == 32'd0) ? 32'hFFFF_FFFF : sd;
        for (int i = 0; i < int'(n); i++) begin
            sb_q.push_back('{addr: a, data: d, last: (i == int'(n) - 1)});
            a = a + 32'd4;
            d = model_next(m, d);
        end
        mode = m; base_addr = base; seed = sd; len = n;
        start = 1'b1; abort = abort_on_start; out_ready = 1'b0;
        @(posedge sys_clk); #1;
        start = 1'b0; abort = 1'b0;
        if (n == 16'd0) begin
            check("empty_valid", out_valid, 0);
            check("empty_done", done, 1);
            return;
        end
        check("start_valid", out_valid, 1);
        check("start_busy", busy, 1);
        k = 0; rdy = 1'b1; cyc = 0;
        while (sb_q.size() > 0) begin
            if (cyc > 3 * int'(n) + 10) begin
                check("timeout", 0, 1);
                sb_q.delete();
                return;
            end
            b = sb_q[0];
            check("beat_valid", out_valid, 1);
            check("beat_addr", out_addr, b.addr);
            check("beat_data", out_data, b.data);
            check("beat_last", out_last, b.last);
            out_ready = toggle ? rdy : 1'b1;
            if (noisy) begin
                start = 1'b1; len = 16'd0; seed = ~sd; base_addr = ~base;
            end
            if (k == reset_at) begin
                sys_rst_n = 1'b0; start = 1'b0;
                #1;
                check("rst_valid", out_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_last", out_last, 0);
                check("rst_addr", out_addr, 0);
                check("rst_data", out_data, 0);
                @(negedge sys_clk);
                sys_rst_n = 1'b1; out_ready = 1'b0;
                sb_q.delete();
                @(posedge sys_clk); #1;
                check("post_rst_valid", out_valid, 0);
                check("post_rst_done", done, 0);
                return;
            end
            if (k == abort_at) abort = 1'b1;
            @(posedge sys_clk); #1;
            start = 1'b0;
            cyc++;
            if (k == abort_at) begin
                abort = 1'b0; out_ready = 1'b0;
                check("abort_valid", out_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                sb_q.delete();
                return;
            end
            if (out_ready) begin
                void'(sb_q.pop_front());
                k++;
            end
            rdy = !rdy;
        end
        out_ready = 1'b0;
        check("end_valid", out_valid, 0);
        check("end_busy", busy, 0);
        check("end_done", done, 1);
    endtask

    initial begin
        repeat (2) @(posedge sys_clk);
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_last", out_last, 0);
        check("reset_addr", out_addr, 0);
        check("reset_data", out_data, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        burst(2'd0, 32'h1000, 32'd5, 16'd4, 0, -1, -1, 0, 0);
        burst(2'd1, 32'h0, 32'd1, 16'd3, 1, -1, -1, 0, 1);
        @(posedge sys_clk); #1;
        check("done_pulse_width", done, 0);

        burst(2'd2, 32'h40, 32'd0, 16'd2, 0, -1, -1, 0, 0);
        burst(2'd3, 32'hFFFF_FFFC, 32'hA5A5_0F0F, 16'd2, 0, -1, -1, 1, 0);
        burst(2'd0, 32'h0, 32'd0, 16'd0, 0, -1, -1, 0, 0);
        @(posedge sys_clk); #1;
        check("empty_done_width", done, 0);
        check("empty_stays_idle", busy, 0);
        burst(2'd1, 32'h80, 32'd0, 16'd1, 0, -1, -1, 0, 0);

        burst(2'd0, 32'h2000, 32'd100, 16'd8, 0, 2, -1, 0, 0);
        burst(2'd0, 32'h2000, 32'd100, 16'd8, 0, -1, -1, 0, 0);
        burst(2'd2, 32'h3000, 32'h1234_5678, 16'd8, 0, -1, 3, 0, 0);
        burst(2'd2, 32'h3000, 32'h1234_5678, 16'd8, 1, -1, -1, 0, 0);

        abort = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        check("idle_abort_done", done, 0);

        burst(2'd2, $urandom, $urandom, 16'd300, 1, -1, -1, 0, 1);
        burst(2'd1, $urandom, $urandom, 16'd40, 0, -1, -1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
